// File: rtl/mic3_spi_sampler.sv
// mic3_spi_sampler
// SPI master for the Digilent MIC3 PMOD (ADCS7476-style 12-bit ADC that
// returns a 16-bit frame). A free-running sample timer starts a conversion
// every SAMPLE_PERIOD clocks while enable is high. The 12-bit result of each
// frame goes into a small FIFO, which is drained through a valid/ready stream.
//
// Handshake: sample_data/sample_valid present the FIFO head. A sample is
// consumed on every rising clk edge where sample_valid && sample_ready. The
// consumer may raise or lower sample_ready at any time. sample_valid never
// depends combinationally on sample_ready.
//
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   enable         permits new conversions (a running frame always completes)
//   spi_csb        ADC chip select, active low (registered)
//   spi_sck        SPI clock, idle high (registered)
//   spi_miso       ADC serial data out
//   sample_data    FIFO head sample (registered)
//   sample_valid   FIFO non-empty (registered)
//   sample_ready   consumer accepts the head sample
//   fifo_count     FIFO occupancy
//   overrun        sticky flag: a sample was dropped because the FIFO was full
//   overrun_clr    clears overrun (a simultaneous drop wins)
//   dbg_state      current FSM state (0 IDLE, 1 SETUP, 2 SHIFT, 3 HOLD)
module mic3_spi_sampler #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  output logic                          spi_csb,
  output logic                          spi_sck,
  input  logic                          spi_miso,
  output logic [11:0]                   sample_data,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  input  logic                          overrun_clr,
  output logic [1:0]                    dbg_state
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int TMR_W = $clog2(SAMPLE_PERIOD);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Sample timer: counts 0..SAMPLE_PERIOD-1 while enabled, held at 0 otherwise.
  // ---------------------------------------------------------------------------
  logic [TMR_W-1:0] tmr_q;
  logic             tick;

  assign tick = enable && (tmr_q == TMR_W'(SAMPLE_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      tmr_q <= '0;
    end else if (tick) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_q + TMR_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM. div_q times every CLK_DIV-long phase; bit_q counts SCK periods.
  // ---------------------------------------------------------------------------
  state_t           state_q;
  logic             csb_q;
  logic             sck_q;
  logic [DIV_W-1:0] div_q;
  logic [3:0]       bit_q;
  // Only the low 12 bits of the frame are kept; the four leading bits simply
  // shift out of the top of the register.
  logic [11:0]      shift_q;
  logic             div_last;
  logic             push;

  assign div_last = (div_q == DIV_W'(CLK_DIV - 1));
  assign push     = (state_q == ST_HOLD) && div_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      csb_q   <= 1'b1;
      sck_q   <= 1'b1;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A tick in any other state is ignored, so starts never queue up.
          if (tick) begin
            state_q <= ST_SETUP;
            csb_q   <= 1'b0;
            sck_q   <= 1'b1;
            div_q   <= '0;
          end
        end
        ST_SETUP: begin
          if (div_last) begin
            state_q <= ST_SHIFT;
            sck_q   <= 1'b0;
            div_q   <= '0;
            bit_q   <= '0;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        ST_SHIFT: begin
          if (!div_last) begin
            div_q <= div_q + DIV_W'(1);
          end else begin
            div_q <= '0;
            if (!sck_q) begin
              // Rising SCK: the slave changed SDO on the previous falling
              // edge, so it is stable now.
              sck_q   <= 1'b1;
              shift_q <= {shift_q[10:0], spi_miso};
            end else if (bit_q == 4'd15) begin
              state_q <= ST_HOLD;
            end else begin
              sck_q <= 1'b0;
              bit_q <= bit_q + 4'd1;
            end
          end
        end
        ST_HOLD: begin
          if (div_last) begin
            state_q <= ST_IDLE;
            csb_q   <= 1'b1;
            div_q   <= '0;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          csb_q   <= 1'b1;
          sck_q   <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sample FIFO with registered head/valid outputs.
  // ---------------------------------------------------------------------------
  logic [11:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q;
  logic [11:0]      head_q, head_d;
  logic             ovr_q;
  logic             pop, full, do_write, drop;

  assign pop      = valid_q && sample_ready;
  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  // When full, a simultaneous pop frees the slot the push needs.
  assign do_write = push && (!full || pop);
  assign drop     = push && full && !pop;

  always_comb begin
    count_d  = count_q + CNT_W'(do_write) - CNT_W'(pop);
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    // The new head may be the word being written this cycle (push into empty).
    if (do_write && (wr_ptr_q == rd_ptr_d)) begin
      head_d = shift_q;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      if (do_write) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= (count_d != '0);
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_q <= 1'b0;
    end else if (drop) begin
      ovr_q <= 1'b1;
    end else if (overrun_clr) begin
      ovr_q <= 1'b0;
    end
  end

  assign spi_csb      = csb_q;
  assign spi_sck      = sck_q;
  assign sample_data  = head_q;
  assign sample_valid = valid_q;
  assign fifo_count   = count_q;
  assign overrun      = ovr_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mic3_spi_sampler.sv
// Directed bench for mic3_spi_sampler with a behavioural MIC3 slave.
module tb_mic3_spi_sampler;
  localparam int CLK_DIV       = 4;
  localparam int SAMPLE_PERIOD = 1000;
  localparam int FIFO_DEPTH    = 8;

  // ---------------------------------------------------------------- clock/reset
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        spi_miso = 1'b0;
  logic        sample_ready = 1'b0;
  logic        overrun_clr = 1'b0;
  logic        spi_csb, spi_sck, sample_valid, overrun;
  logic [11:0] sample_data;
  logic [3:0]  fifo_count;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  mic3_spi_sampler #(
    .CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SAMPLE_PERIOD), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .spi_csb(spi_csb), .spi_sck(spi_sck), .spi_miso(spi_miso),
    .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .fifo_count(fifo_count),
    .overrun(overrun), .overrun_clr(overrun_clr), .dbg_state(dbg_state)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------------------------------------------------------- MIC3 slave
  // Frame value = base_val + 3 * (completed frames since base_idx). A frame cut
  // short by csb rising early does not count.
  logic [11:0] base_val = 12'h900;
  int          base_idx = 0;
  int          done_frames = 0;
  logic [15:0] frame_word = '0;
  int          bit_idx = -1;
  bit          frame_active = 1'b0;

  always @(negedge spi_csb) begin
    frame_word   = {4'h0, base_val + 12'(3 * (done_frames - base_idx))};
    bit_idx      = 15;
    frame_active = 1'b1;
  end
  always @(negedge spi_sck) begin
    if (!spi_csb && bit_idx >= 0) begin
      spi_miso = frame_word[bit_idx];
      bit_idx  = bit_idx - 1;
    end
  end
  always @(posedge spi_csb) begin
    if (frame_active && bit_idx < 0) done_frames++;
    frame_active = 1'b0;
    bit_idx      = -1;
  end

  // ---------------------------------------------------------------- monitors
  logic [11:0] got_q[$];
  logic [11:0] exp_q[$];
  int          start_cyc[$];
  logic        prev_csb = 1'b1, prev_sck = 1'b1;
  int          low_len = 0, rises = 0, first_fall = -1;
  int          last_low_len = 0, last_rises = 0, last_first_fall = 0;
  int          frames_done = 0;
  bit          sck_bad = 1'b0;

  always begin
    @(negedge clk);
    #1;
    if (sample_valid === 1'b1 && sample_ready === 1'b1) got_q.push_back(sample_data);
  end

  always @(negedge clk) begin
    if (prev_csb && !spi_csb) begin
      low_len = 1; rises = 0; first_fall = -1;
      start_cyc.push_back(cyc);
      if (spi_sck !== 1'b1) sck_bad = 1'b1;
    end else if (!spi_csb) begin
      low_len++;
      if (!prev_sck && spi_sck) rises++;
      if (prev_sck && !spi_sck && first_fall < 0) first_fall = low_len - 1;
    end
    if (!prev_csb && spi_csb) begin
      last_low_len = low_len; last_rises = rises; last_first_fall = first_fall;
      frames_done++;
      if (spi_sck !== 1'b1) sck_bad = 1'b1;
    end
    prev_csb = spi_csb;
    prev_sck = spi_sck;
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic wait_idle_and_reset(input logic [11:0] val);
    bit ok = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (dbg_state == 2'd0 && spi_csb === 1'b1) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL restart_idle: got state %0d want 0", dbg_state); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    base_val = val;
    base_idx = done_frames;
  endtask

  task automatic wait_frames(input int target, input int bound, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (frames_done >= target) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL %s: got %0d frames want %0d", name, frames_done, target); end
  endtask

  task automatic wait_pops(input int target, input int bound, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (got_q.size() >= target) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL %s: got %0d samples want %0d", name, got_q.size(), target); end
  endtask

  task automatic wait_csb_low(input int bound, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (spi_csb === 1'b0) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL %s: csb never fell", name); end
  endtask

  task automatic check_drain(input int gb, input string name);
    logic [11:0] e;
    checks++; if (got_q.size() - gb !== FIFO_DEPTH) begin errors++; $display("FAIL %s_len: got %0d want %0d", name, got_q.size() - gb, FIFO_DEPTH); end
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      e = exp_q.pop_front();
      checks++; if (got_q[gb + k] !== e) begin errors++; $display("FAIL %s[%0d]: got %h want %h", name, k, got_q[gb + k], e); end
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; sample_ready = 1'b0; overrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (spi_csb !== 1'b1) begin errors++; $display("FAIL reset_csb: got %b want 1", spi_csb); end
    checks++; if (spi_sck !== 1'b1) begin errors++; $display("FAIL reset_sck: got %b want 1", spi_sck); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", sample_valid); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    checks++; if (sample_data !== 12'h000) begin errors++; $display("FAIL reset_data: got %h want 000", sample_data); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    reset = 1'b0;
  endtask

  task automatic test_stream();
    int gb, sb;
    wait_idle_and_reset(12'h900);
    sample_ready = 1'b1;
    gb = got_q.size(); sb = start_cyc.size();
    enable = 1'b1;
    wait_pops(gb + 3, 4000, "stream_wait");
    checks++; if (got_q[gb] !== 12'h900) begin errors++; $display("FAIL stream_s0: got %h want 900", got_q[gb]); end
    checks++; if (got_q[gb + 1] !== 12'h903) begin errors++; $display("FAIL stream_s1: got %h want 903", got_q[gb + 1]); end
    checks++; if (got_q[gb + 2] !== 12'h906) begin errors++; $display("FAIL stream_s2: got %h want 906", got_q[gb + 2]); end
    checks++; if (start_cyc[sb + 1] - start_cyc[sb] !== SAMPLE_PERIOD) begin errors++; $display("FAIL stream_gap1: got %0d want %0d", start_cyc[sb + 1] - start_cyc[sb], SAMPLE_PERIOD); end
    checks++; if (start_cyc[sb + 2] - start_cyc[sb + 1] !== SAMPLE_PERIOD) begin errors++; $display("FAIL stream_gap2: got %0d want %0d", start_cyc[sb + 2] - start_cyc[sb + 1], SAMPLE_PERIOD); end
    checks++; if (last_low_len !== 136) begin errors++; $display("FAIL wave_csb_low: got %0d want 136", last_low_len); end
    checks++; if (last_rises !== 16) begin errors++; $display("FAIL wave_sck_rises: got %0d want 16", last_rises); end
    checks++; if (last_first_fall !== 4) begin errors++; $display("FAIL wave_first_fall: got %0d want 4", last_first_fall); end
    checks++; if (sck_bad !== 1'b0) begin errors++; $display("FAIL wave_sck_at_csb_edge: got %b want 0", sck_bad); end
  endtask

  task automatic test_overrun();
    int fd, gb;
    wait_idle_and_reset(12'h900);
    sample_ready = 1'b0;
    fd = frames_done;
    enable = 1'b1;
    wait_frames(fd + 10, 11000, "ovr_wait");
    enable = 1'b0;
    @(negedge clk);
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL ovr_count: got %0d want 8", fifo_count); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", overrun); end
    checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b want 1", sample_valid); end
    checks++; if (sample_data !== 12'h900) begin errors++; $display("FAIL ovr_head: got %h want 900", sample_data); end
    for (int k = 0; k < FIFO_DEPTH; k++) exp_q.push_back(12'h900 + 12'(3 * k));
    gb = got_q.size();
    sample_ready = 1'b1;
    repeat (12) @(negedge clk);
    check_drain(gb, "ovr_drain");
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL ovr_valid_after: got %b want 0", sample_valid); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL ovr_count_after: got %0d want 0", fifo_count); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr: got %b want 0", overrun); end
  endtask

  task automatic test_full_push_pop();
    int fd, gb;
    wait_idle_and_reset(12'h900);
    sample_ready = 1'b0;
    fd = frames_done;
    enable = 1'b1;
    wait_frames(fd + 8, 9000, "full_wait");
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d want 8", fifo_count); end
    wait_csb_low(1100, "full_csb");
    // Land on the final csb-low clock, whose closing edge carries the push.
    repeat (135) @(negedge clk);
    checks++; if (spi_csb !== 1'b0) begin errors++; $display("FAIL full_last_low: got %b want 0", spi_csb); end
    gb = got_q.size();
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
    enable = 1'b0;
    checks++; if (spi_csb !== 1'b1) begin errors++; $display("FAIL full_csb_up: got %b want 1", spi_csb); end
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL full_pp_count: got %0d want 8", fifo_count); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL full_pp_overrun: got %b want 0", overrun); end
    checks++; if (got_q[gb] !== 12'h900) begin errors++; $display("FAIL full_pp_pop: got %h want 900", got_q[gb]); end
    for (int k = 1; k <= FIFO_DEPTH; k++) exp_q.push_back(12'h900 + 12'(3 * k));
    gb = got_q.size();
    sample_ready = 1'b1;
    repeat (12) @(negedge clk);
    check_drain(gb, "full_drain");
  endtask

  task automatic test_reset_mid_frame();
    int fd, gb, r;
    logic ps;
    wait_idle_and_reset(12'h900);
    sample_ready = 1'b0;
    fd = frames_done;
    enable = 1'b1;
    wait_frames(fd + 1, 1300, "rst_first");
    checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL rst_pre_count: got %0d want 1", fifo_count); end
    wait_csb_low(1100, "rst_csb");
    r = 0; ps = spi_sck;
    for (int i = 0; i < 200 && r < 7; i++) begin
      @(negedge clk);
      if (!ps && spi_sck) r++;
      ps = spi_sck;
    end
    checks++; if (r !== 7) begin errors++; $display("FAIL rst_sck_edges: got %0d want 7", r); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (spi_csb !== 1'b1) begin errors++; $display("FAIL rst_csb: got %b want 1", spi_csb); end
    checks++; if (spi_sck !== 1'b1) begin errors++; $display("FAIL rst_sck: got %b want 1", spi_sck); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", sample_valid); end
    reset = 1'b0;
    sample_ready = 1'b1;
    gb = got_q.size();
    wait_pops(gb + 1, 1300, "rst_next");
    checks++; if (got_q[gb] !== 12'h903) begin errors++; $display("FAIL rst_next_val: got %h want 903", got_q[gb]); end
    checks++; if (last_rises !== 16) begin errors++; $display("FAIL rst_next_rises: got %0d want 16", last_rises); end
    checks++; if (last_low_len !== 136) begin errors++; $display("FAIL rst_next_low: got %0d want 136", last_low_len); end
  endtask

  task automatic test_enable_drop();
    int gb, sc;
    wait_idle_and_reset(12'hA00);
    sample_ready = 1'b1;
    gb = got_q.size();
    enable = 1'b1;
    wait_csb_low(1100, "en_csb");
    repeat (20) @(negedge clk);
    enable = 1'b0;
    wait_pops(gb + 1, 300, "en_pop");
    checks++; if (got_q[gb] !== 12'hA00) begin errors++; $display("FAIL en_val: got %h want a00", got_q[gb]); end
    checks++; if (last_low_len !== 136) begin errors++; $display("FAIL en_low: got %0d want 136", last_low_len); end
    sc = start_cyc.size();
    repeat (5000) @(negedge clk);
    checks++; if (start_cyc.size() !== sc) begin errors++; $display("FAIL en_no_start: got %0d starts want %0d", start_cyc.size(), sc); end
    checks++; if (spi_csb !== 1'b1) begin errors++; $display("FAIL en_csb_idle: got %b want 1", spi_csb); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL en_state: got %0d want 0", dbg_state); end
    checks++; if (sck_bad !== 1'b0) begin errors++; $display("FAIL sck_at_csb_edge: got %b want 0", sck_bad); end
  endtask

  // ---------------------------------------------------------------- sequence + report
  initial begin
    test_reset();
    test_stream();
    test_overrun();
    test_full_push_pop();
    test_reset_mid_frame();
    test_enable_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
